sc_b2s_counter2: RTL and testbench

- Stochastic-to-binary converter placed directly downstream of the 2-output stochastic Gaussian-blur kernel.
- Accumulates the kernel's 2 output bitstreams over a fixed window of 2^WLOG valid samples.
- Presents one binary count per lane with a valid/ready handshake.
- Converts SC results back to binary for readout and error measurement against the floating-point reference model.

---
 rtl/sc_pkg.sv | 17 +
 rtl/sc_lane_counter.sv | 36 +++
 rtl/sc_b2s_counter2.sv | 99 +++++++++
 tb/tb_sc_b2s_counter2.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// Shared types and constants for the stochastic-to-binary window counter.
package sc_pkg;

  localparam int unsigned DefLanes = 2;
  localparam int unsigned DefWlog  = 8;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StHold
  } state_e;

  function automatic int unsigned win_len(input int unsigned wlog);
    return 32'd1 << wlog;
  endfunction

endpackage

// File: rtl/sc_lane_counter.sv
// One lane's population counter: clears on clr, adds bit_in when en is high.
module sc_lane_counter
  import sc_pkg::*;
#(
  parameter int unsigned CW = DefWlog + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic          bit_in,
  output logic [CW-1:0] cnt
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(bit_in);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/sc_b2s_counter2.sv
// Accumulates LANES stochastic bitstreams over 2^WLOG valid samples and
// presents the per-lane ones-count with a valid/ready handshake.
module sc_b2s_counter2
  import sc_pkg::*;
#(
  parameter int unsigned LANES = DefLanes,
  parameter int unsigned WLOG  = DefWlog,
  parameter int unsigned CW    = WLOG + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  input  logic [LANES-1:0]    bs,
  output logic                busy,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LANES*CW-1:0] count
);

  localparam logic [WLOG-1:0] LastIdx = WLOG'(win_len(WLOG) - 1);

  state_e          state_q, state_d;
  logic [WLOG-1:0] smp_q, smp_d;
  logic            busy_q, busy_d;
  logic            out_valid_q, out_valid_d;
  logic            clr, en;

  always_comb begin
    state_d = state_q;
    smp_d   = smp_q;
    clr     = 1'b0;
    en      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StAccum;
          smp_d   = '0;
          clr     = 1'b1;
        end
      end
      StAccum: begin
        if (in_valid) begin
          en    = 1'b1;
          // Sample counter wraps to 0 exactly as the window closes.
          smp_d = smp_q + WLOG'(1);
          if (smp_q == LastIdx) begin
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (out_ready) begin
          if (start) begin
            state_d = StAccum;
            smp_d   = '0;
            clr     = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d      = (state_d == StAccum);
    out_valid_d = (state_d == StHold);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      smp_q       <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      smp_q       <= smp_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    sc_lane_counter #(
      .CW(CW)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .en    (en),
      .bit_in(bs[gi]),
      .cnt   (count[gi*CW +: CW])
    );
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sc_b2s_counter2.sv
// Randomized bench for sc_b2s_counter2 against a window-level popcount model.
module tb_sc_b2s_counter2;

  localparam int unsigned Lanes = 2;
  localparam int unsigned Wlog  = 8;
  localparam int unsigned Cw    = Wlog + 1;
  localparam int unsigned Win   = 1 << Wlog;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic                in_valid;
  logic [Lanes-1:0]    bs;
  logic                busy;
  logic                out_valid;
  logic                out_ready;
  logic [Lanes*Cw-1:0] count;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  logic [1:0]  win_q[$];
  int unsigned exp_cnt[Lanes];

  always #5 clk = ~clk;

  sc_b2s_counter2 #(
    .LANES(Lanes),
    .WLOG (Wlog),
    .CW   (Cw)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .bs       (bs),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .count    (count)
  );

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned lane_cnt(input int lane);
    return int'(count[lane*Cw +: Cw]);
  endfunction

  task automatic check_counts(input string tag, input int unsigned e0, input int unsigned e1);
    check_eq({tag, "_lane0"}, lane_cnt(0), e0);
    check_eq({tag, "_lane1"}, lane_cnt(1), e1);
  endtask

  // Reference: expected counts are plain popcounts of the queued window.
  task automatic model_window();
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    foreach (win_q[i]) begin
      exp_cnt[0] += win_q[i][0];
      exp_cnt[1] += win_q[i][1];
    end
  endtask

  task automatic do_start();
    start    = 1'b1;
    in_valid = 1'($urandom);
    bs       = 2'($urandom);
    tick();
    start = 1'b0;
    check_eq("start_busy", busy, 1);
    check_eq("start_ovalid", out_valid, 0);
    check_counts("start_clr", 0, 0);
  endtask

  // stall: 0 none, 1 one stall (bs=11) before each sample, 2 random 0..2 stalls.
  task automatic feed_window(input int stall);
    int unsigned ns;
    model_window();
    for (int i = 0; i < Win; i++) begin
      ns = (stall == 0) ? 0 : (stall == 1) ? 1 : $urandom_range(2, 0);
      for (int s = 0; s < int'(ns); s++) begin
        in_valid = 1'b0;
        bs       = (stall == 1) ? 2'b11 : 2'($urandom);
        start    = 1'($urandom);
        tick();
        check_eq("stall_ovalid", out_valid, 0);
        check_eq("stall_busy", busy, 1);
      end
      in_valid = 1'b1;
      bs       = win_q[i];
      start    = 1'($urandom);
      tick();
      if (i < Win - 1) begin
        check_eq("accum_ovalid", out_valid, 0);
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check_eq("hold_ovalid", out_valid, 1);
    check_eq("hold_busy", busy, 0);
    check_counts("hold", exp_cnt[0], exp_cnt[1]);
  endtask

  task automatic hold_and_accept(input int hold_n, input bit b2b);
    out_ready = 1'b0;
    for (int k = 0; k < hold_n; k++) begin
      in_valid = 1'($urandom);
      bs       = 2'($urandom);
      start    = 1'($urandom);
      tick();
      check_eq("stall_hold_ovalid", out_valid, 1);
      check_counts("stall_hold", exp_cnt[0], exp_cnt[1]);
    end
    out_ready = 1'b1;
    start     = b2b;
    in_valid  = 1'($urandom);
    bs        = 2'($urandom);
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    check_eq("accept_ovalid", out_valid, 0);
    check_eq("accept_busy", busy, b2b);
    if (b2b) check_counts("b2b_clr", 0, 0);
  endtask

  task automatic fill_const(input logic [1:0] v);
    win_q.delete();
    for (int i = 0; i < Win; i++) win_q.push_back(v);
  endtask

  task automatic fill_rand();
    win_q.delete();
    for (int i = 0; i < Win; i++) win_q.push_back(2'($urandom));
  endtask

  initial begin
    logic [7:0] lfsr;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; bs = '0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ovalid", out_valid, 0);
    check_counts("rst", 0, 0);

    // IDLE ignores samples.
    in_valid = 1'b1; bs = 2'b11;
    tick(); tick();
    in_valid = 1'b0;
    check_eq("idle_busy", busy, 0);
    check_counts("idle", 0, 0);

    fill_const(2'b11);
    do_start();
    feed_window(0);
    check_counts("all_ones", 256, 256);
    hold_and_accept(0, 1'b0);

    win_q.delete();
    for (int i = 0; i < Win; i++) win_q.push_back({1'(i % 2 == 0), 1'b0});
    do_start();
    feed_window(0);
    check_counts("alt_lane1", 0, 128);
    hold_and_accept(2, 1'b0);

    fill_const(2'b01);
    do_start();
    feed_window(1);
    hold_and_accept(10, 1'b1);

    fill_rand();
    feed_window(2);
    hold_and_accept(3, 1'b0);

    // Reset mid-window discards the partial result.
    fill_const(2'b11);
    do_start();
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1; bs = 2'b11;
      tick();
      check_eq("pre_rst_ovalid", out_valid, 0);
    end
    rst = 1'b1; in_valid = 1'b0;
    tick();
    rst = 1'b0;
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_ovalid", out_valid, 0);
    check_counts("midrst", 0, 0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; bs = 2'b11;
      tick();
      check_eq("post_rst_ovalid", out_valid, 0);
    end
    in_valid = 1'b0;

    fill_const(2'b10);
    do_start();
    feed_window(2);
    check_counts("lane1_only", 0, 256);
    hold_and_accept(1, 1'b0);

    // LFSR comparator streams for 64/256 and 192/256.
    win_q.delete();
    lfsr = 8'h5a;
    for (int i = 0; i < Win; i++) begin
      win_q.push_back({1'(lfsr < 8'd192), 1'(lfsr < 8'd64)});
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
    do_start();
    feed_window(0);
    hold_and_accept(0, 1'b0);

    // Mid-HOLD reset.
    fill_rand();
    do_start();
    feed_window(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("holdrst_ovalid", out_valid, 0);
    check_counts("holdrst", 0, 0);

    for (int w = 0; w < 3; w++) begin
      fill_rand();
      do_start();
      feed_window(2);
      hold_and_accept($urandom_range(4, 0), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
